// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core slice: datapath widths, opcodes, FSM encoding and
// instruction field layout.
package cpu_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned PC_W      = 10;
    localparam int unsigned ROM_DEPTH = 1024;
    localparam int unsigned NREGS     = 16;
    localparam int unsigned RIDX_W    = 4;
    localparam int unsigned NUM_IRQ   = 3;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_AND  = 4'h3;
    localparam opcode_t OP_OR   = 4'h4;
    localparam opcode_t OP_XOR  = 4'h5;
    localparam opcode_t OP_NOT  = 4'h6;
    localparam opcode_t OP_LI   = 4'h7;
    localparam opcode_t OP_LD   = 4'h8;
    localparam opcode_t OP_ST   = 4'h9;
    localparam opcode_t OP_JMP  = 4'hA;
    localparam opcode_t OP_JZ   = 4'hB;
    localparam opcode_t OP_JNZ  = 4'hC;
    localparam opcode_t OP_CALL = 4'hD;
    localparam opcode_t OP_RET  = 4'hE;
    localparam opcode_t OP_NOPF = 4'hF;

    typedef enum logic {
        ST_EXEC     = 1'b0,
        ST_BUS_WAIT = 1'b1
    } state_e;

    // Field layout: op [15:12], d [11:8], a [7:4], b [3:0]; jump target overlays [9:0].
    typedef struct packed {
        opcode_t               op;
        logic [RIDX_W-1:0]     d;
        logic [RIDX_W-1:0]     a;
        logic [RIDX_W-1:0]     b;
    } instr_t;

    function automatic logic [PC_W-1:0] instr_target(input instr_t i);
        return {i.d[1:0], i.a, i.b};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU for ops ADD..NOT; c_o is carry (ADD), borrow (SUB), 0 for logic ops.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  opcode_t           op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        case (op_i)
            OP_ADD:  {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: begin
                result_o = a_i - b_i;
                c_o      = (a_i < b_i);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            default: result_o = '0;
        endcase
    end

    assign z_o = (result_o == '0);

endmodule

// File: rtl/cpu_core.sv
// 8-bit RISC core: 1024x16 program ROM, 16x8 register file, return stack, single-transfer bus FSM.
// Defining CPU_INTERRUPTS_EN adds three level interrupts with IE flag and shadow Z/C.
module cpu_core
    import cpu_pkg::*;
#(
    parameter                   PROG_FILE    = "progfile.dat",
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [PC_W-1:0]  INT_VEC_BASE = 10'h3F0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupciones,
    input  logic               enable_wishbone,
    output logic               rd,
    output logic               wr,
    output logic [ADDR_W-1:0]  dir,
    input  logic [DATA_W-1:0]  entradaDispositivo,
    output logic [DATA_W-1:0]  salidaDispositivo
);

    localparam int unsigned     SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

    // Program image: all-NOP until the memory-init flow loads PROG_FILE into it.
    logic [INSTR_W-1:0] rom_mem [ROM_DEPTH] = '{default: '0};
    logic               unused_prog_file;
    assign unused_prog_file = ^PROG_FILE;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                z_q, z_d, c_q, c_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]   dir_q, dir_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   rf_q [NREGS];
    logic [PC_W-1:0]     stack_q [STACK_DEPTH];

    logic                rf_we, stk_we, irq_req;
    logic [RIDX_W-1:0]   rf_wa;
    logic [DATA_W-1:0]   rf_wd, ra, rb, rdv, alu_res;
    logic [PC_W-1:0]     stk_wd, pc_inc;
    logic [SP_W-1:0]     sp_inc, sp_dec;
    logic                alu_z, alu_c;
    instr_t              instr;

    assign instr  = instr_t'(rom_mem[pc_q]);
    assign ra     = rf_q[instr.a];
    assign rb     = rf_q[instr.b];
    assign rdv    = rf_q[instr.d];
    assign pc_inc = pc_q + PC_W'(1);
    assign sp_inc = (sp_q == SP_LAST) ? '0 : sp_q + SP_W'(1);
    assign sp_dec = (sp_q == '0) ? SP_LAST : sp_q - SP_W'(1);

`ifdef CPU_INTERRUPTS_EN
    logic            ie_q, ie_d, zs_q, zs_d, cs_q, cs_d;
    logic [PC_W-1:0] irq_vec;

    assign irq_req = ie_q && (|interrupciones);

    // Bit 0 has the highest priority.
    always_comb begin
        if (interrupciones[0])      irq_vec = INT_VEC_BASE;
        else if (interrupciones[1]) irq_vec = INT_VEC_BASE + PC_W'(4);
        else                        irq_vec = INT_VEC_BASE + PC_W'(8);
    end
`else
    logic unused_irq;
    assign unused_irq = ^interrupciones;
    assign irq_req    = 1'b0;
`endif

    cpu_alu u_alu (
        .a_i      (ra),
        .b_i      (rb),
        .op_i     (instr.op),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EXEC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EXEC:     if (!irq_req && (instr.op == OP_LD || instr.op == OP_ST)) state_d = ST_BUS_WAIT;
            ST_BUS_WAIT: if (enable_wishbone) state_d = ST_EXEC;
            default:     state_d = ST_EXEC;
        endcase
    end

    // Datapath / output next-values; bus outputs only change on issue or completion.
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        z_d    = z_q;
        c_d    = c_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        dir_d  = dir_q;
        dout_d = dout_q;
        rf_we  = 1'b0;
        rf_wa  = instr.d;
        rf_wd  = alu_res;
        stk_we = 1'b0;
        stk_wd = pc_inc;
`ifdef CPU_INTERRUPTS_EN
        ie_d   = ie_q;
        zs_d   = zs_q;
        cs_d   = cs_q;
`endif
        if (state_q == ST_BUS_WAIT) begin
            if (enable_wishbone) begin
                rf_we = rd_q;
                rf_wd = entradaDispositivo;
                rd_d  = 1'b0;
                wr_d  = 1'b0;
                pc_d  = pc_inc;
            end
        end else if (irq_req) begin
            stk_we = 1'b1;
            stk_wd = pc_q;
            sp_d   = sp_inc;
`ifdef CPU_INTERRUPTS_EN
            pc_d   = irq_vec;
            ie_d   = 1'b0;
            zs_d   = z_q;
            cs_d   = c_q;
`endif
        end else begin
            pc_d = pc_inc;
            case (instr.op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    rf_we = 1'b1;
                    z_d   = alu_z;
                    c_d   = alu_c;
                end
                OP_LI: begin
                    rf_we = 1'b1;
                    rf_wd = {instr.a, instr.b};
                end
                OP_LD: begin
                    rd_d  = 1'b1;
                    dir_d = {ra, rb};
                    pc_d  = pc_q;
                end
                OP_ST: begin
                    wr_d   = 1'b1;
                    dir_d  = {ra, rb};
                    dout_d = rdv;
                    pc_d   = pc_q;
                end
                OP_JMP:  pc_d = instr_target(instr);
                OP_JZ:   if (z_q)  pc_d = instr_target(instr);
                OP_JNZ:  if (!z_q) pc_d = instr_target(instr);
                OP_CALL: begin
                    stk_we = 1'b1;
                    sp_d   = sp_inc;
                    pc_d   = instr_target(instr);
                end
                OP_RET: begin
                    sp_d = sp_dec;
                    pc_d = stack_q[sp_dec];
`ifdef CPU_INTERRUPTS_EN
                    if (instr.b[0]) begin
                        z_d  = zs_q;
                        c_d  = cs_q;
                        ie_d = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            sp_q   <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            dir_q  <= '0;
            dout_q <= '0;
            for (int i = 0; i < NREGS; i++)       rf_q[i]    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`ifdef CPU_INTERRUPTS_EN
            ie_q   <= 1'b1;
            zs_q   <= 1'b0;
            cs_q   <= 1'b0;
`endif
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            z_q    <= z_d;
            c_q    <= c_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            dir_q  <= dir_d;
            dout_q <= dout_d;
            if (rf_we && rf_wa != '0) rf_q[rf_wa] <= rf_wd;
            if (stk_we)               stack_q[sp_q] <= stk_wd;
`ifdef CPU_INTERRUPTS_EN
            ie_q   <= ie_d;
            zs_q   <= zs_d;
            cs_q   <= cs_d;
`endif
        end
    end

    assign rd                = rd_q;
    assign wr                = wr_q;
    assign dir               = dir_q;
    assign salidaDispositivo = dout_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed program from the block's test list, then random ROM images
// and random bus/interrupt/reset stimulus checked against an instruction-level model.
module tb_cpu_core;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  irq;
    logic        en;
    logic [7:0]  din;
    logic        rd, wr;
    logic [15:0] dir;
    logic [7:0]  dout;

    cpu_core #(.STACK_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .interrupciones     (irq),
        .enable_wishbone    (en),
        .rd                 (rd),
        .wr                 (wr),
        .dir                (dir),
        .entradaDispositivo (din),
        .salidaDispositivo  (dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference model
    logic [15:0] prog [1024];
    int m_pc, m_sp, m_dir, m_dout;
    int m_rf [16];
    int m_stk [DEPTH];
    bit m_z, m_c, m_wait, m_rd, m_wr, m_ie, m_zs, m_cs;

    task automatic model_step(input bit rst, input bit e, input logic [2:0] ir, input int di);
        logic [15:0] ins;
        int op, d, a, b, tgt, va, vb, res, nxt;
        if (rst) begin
            m_pc = 0; m_sp = 0; m_z = 0; m_c = 0; m_wait = 0; m_rd = 0; m_wr = 0;
            m_dir = 0; m_dout = 0; m_ie = 1; m_zs = 0; m_cs = 0;
            foreach (m_rf[i])  m_rf[i] = 0;
            foreach (m_stk[i]) m_stk[i] = 0;
            return;
        end
        ins = prog[m_pc];
        op = int'(ins[15:12]); d = int'(ins[11:8]); a = int'(ins[7:4]); b = int'(ins[3:0]);
        tgt = int'(ins[9:0]);
        nxt = (m_pc + 1) % 1024;
        if (m_wait) begin
            if (e) begin
                if (m_rd && d != 0) m_rf[d] = di;
                m_rd = 0; m_wr = 0; m_wait = 0; m_pc = nxt;
            end
            return;
        end
`ifdef CPU_INTERRUPTS_EN
        if (m_ie && ir != 3'b000) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % DEPTH;
            m_zs = m_z; m_cs = m_c; m_ie = 0;
            m_pc = 'h3F0 + 4 * (ir[0] ? 0 : (ir[1] ? 1 : 2));
            return;
        end
`endif
        va = m_rf[a]; vb = m_rf[b];
        case (op)
            1, 2, 3, 4, 5, 6: begin
                case (op)
                    1: res = va + vb;
                    2: res = va - vb;
                    3: res = va & vb;
                    4: res = va | vb;
                    5: res = va ^ vb;
                    default: res = 255 - va;
                endcase
                m_c = (op == 1) ? (res > 255) : ((op == 2) ? (res < 0) : 1'b0);
                res = (res + 256) % 256;
                m_z = (res == 0);
                if (d != 0) m_rf[d] = res;
                m_pc = nxt;
            end
            7: begin
                if (d != 0) m_rf[d] = int'(ins[7:0]);
                m_pc = nxt;
            end
            8: begin m_wait = 1; m_rd = 1; m_dir = va * 256 + vb; end
            9: begin m_wait = 1; m_wr = 1; m_dir = va * 256 + vb; m_dout = m_rf[d]; end
            10: m_pc = tgt;
            11: m_pc = m_z ? tgt : nxt;
            12: m_pc = m_z ? nxt : tgt;
            13: begin m_stk[m_sp] = nxt; m_sp = (m_sp + 1) % DEPTH; m_pc = tgt; end
            14: begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                m_pc = m_stk[m_sp];
`ifdef CPU_INTERRUPTS_EN
                if (b % 2 == 1) begin m_z = m_zs; m_c = m_cs; m_ie = 1; end
`endif
            end
            default: m_pc = nxt;
        endcase
    endtask

    task automatic check_cycle();
        check_eq("rd",   32'(rd),        32'(m_rd));
        check_eq("wr",   32'(wr),        32'(m_wr));
        check_eq("dir",  32'(dir),       m_dir);
        check_eq("dout", 32'(dout),      m_dout);
        check_eq("pc",   32'(dut.pc_q),  m_pc);
        check_eq("z",    32'(dut.z_q),   32'(m_z));
        check_eq("c",    32'(dut.c_q),   32'(m_c));
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) check_eq($sformatf("r%0d", i), 32'(dut.rf_q[i]), m_rf[i]);
    endtask

    task automatic cycle(input bit rst, input bit e, input logic [2:0] ir, input logic [7:0] di);
        reset = rst; en = e; irq = ir; din = di;
        @(posedge clk);
        model_step(rst, e, ir, int'(di));
        #1;
        check_cycle();
    endtask

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) dut.rom_mem[i] = prog[i];
    endtask

    int  wcnt, nbus, wr_cycles;
    bit  seen_st;
    bit  rst_r, en_r;
    logic [2:0] ir_r;

    initial begin
        reset = 1'b1; en = 1'b0; irq = 3'b000; din = 8'h00;

        // Directed program
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
        prog[0]     = 16'h7105;  prog[1]     = 16'h7203;  prog[2]     = 16'h1312;
        prog[3]     = 16'h74FF;  prog[4]     = 16'h1542;  prog[5]     = 16'hD020;
        prog[6]     = 16'h2611;  prog[7]     = 16'hC3FF;  prog[8]     = 16'hB010;
        prog['h10]  = 16'h7712;  prog['h11]  = 16'h7834;  prog['h12]  = 16'h9178;
        prog['h13]  = 16'h8978;  prog['h14]  = 16'h8978;  prog['h20]  = 16'hE000;
        prog['h3F4] = 16'hE001;
        load_rom();

        cycle(1, 0, 3'b000, 8'h00);
        cycle(1, 0, 3'b000, 8'h00);
        check_eq("rst_pc",   32'(dut.pc_q), 0);
        check_eq("rst_sp",   32'(dut.sp_q), 0);
        check_eq("rst_dir",  32'(dir), 0);
        check_eq("rst_dout", 32'(dout), 0);

        wcnt = 0; nbus = 0; wr_cycles = 0; seen_st = 0;
        for (int t = 0; t < 30; t++) begin
            wcnt = m_wait ? wcnt + 1 : 0;
            en_r = (wcnt == 4) && (nbus < 2);
            if (en_r) nbus++;
            cycle(0, en_r, 3'b000, 8'hA5);
            if (wr) wr_cycles++;
            if (wr && !seen_st) begin
                seen_st = 1;
                check_eq("st_dir",  32'(dir), 32'h1234);
                check_eq("st_data", 32'(dout), 32'h05);
            end
        end
        check_eq("st_seen",   32'(seen_st), 1);
        check_eq("wr_held",   wr_cycles, 4);
        check_eq("r3_add",    32'(dut.rf_q[3]), 32'h08);
        check_eq("r5_carry",  32'(dut.rf_q[5]), 32'h02);
        check_eq("r6_sub",    32'(dut.rf_q[6]), 32'h00);
        check_eq("r9_ld",     32'(dut.rf_q[9]), 32'hA5);
        check_eq("ld_keep_z", 32'(dut.z_q), 1);
        check_eq("wait_rd",   32'(rd), 1);
        check_regs();

        // Reset while stalled on a read
        cycle(1, 0, 3'b000, 8'h00);
        check_eq("rstw_rd", 32'(rd), 0);
        check_eq("rstw_wr", 32'(wr), 0);
        check_eq("rstw_pc", 32'(dut.pc_q), 0);

`ifdef CPU_INTERRUPTS_EN
        cycle(0, 0, 3'b110, 8'h00);
        check_eq("irq_pc", 32'(dut.pc_q), 32'h3F4);
        check_eq("irq_ie", 32'(dut.ie_q), 0);
        cycle(0, 0, 3'b000, 8'h00);
        check_eq("reti_pc", 32'(dut.pc_q), 0);
        check_eq("reti_ie", 32'(dut.ie_q), 1);
`endif

        // Random ROM images with random bus timing, interrupts and resets
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 1024; i++) prog[i] = 16'($urandom);
            load_rom();
            cycle(1, 0, 3'b000, 8'h00);
            for (int t = 0; t < 2000; t++) begin
                rst_r = ($urandom_range(0, 199) == 0);
                en_r  = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
                ir_r  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                cycle(rst_r, en_r, ir_r, 8'($urandom));
            end
            check_regs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
